// File: rtl/calc_pkg.sv
// Shared key codes, states and operator encoding
// for the keypad calculator core.
package calc_pkg;

   localparam logic [3:0] KEY_PLUS  = 4'd10;
   localparam logic [3:0] KEY_MINUS = 4'd11;
   localparam logic [3:0] KEY_MUL   = 4'd12;
   localparam logic [3:0] KEY_DIV   = 4'd13;
   localparam logic [3:0] KEY_ENTER = 4'd14;
   localparam logic [3:0] KEY_CLEAR = 4'd15;

   typedef enum logic [2:0] {
      S_OP1,
      S_OPR,
      S_OP2,
      S_EXEC,
      S_DIV
   } calc_state_t;

   // Encoding follows key order: code - KEY_PLUS
   typedef enum logic [1:0] {
      OP_ADD,
      OP_SUB,
      OP_MUL,
      OP_DIV
   } calc_op_t;

   function automatic longint pow10(input int n);
      longint p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

endpackage

// File: rtl/calc_div_seq.sv
// Unsigned restoring divider, one quotient bit
// per cycle; first bit is produced on the start edge.
module calc_div_seq #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quotient,
   output logic         done
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  rem;
   logic [W-1:0]  dvd;
   logic [CW-1:0] cnt;
   logic          run;

   logic [W-1:0] s_rem;
   logic [W-1:0] s_in;
   logic [W:0]   trial;
   logic         q_bit;
   logic [W-1:0] n_rem;

   assign quotient = dvd;

   // One restoring step on either the fresh operands or the running state
   always_comb begin
      s_rem = start ? '0 : rem;
      s_in  = start ? dividend : dvd;
      trial = {s_rem, s_in[W-1]} - {1'b0, divisor};
      q_bit = ~trial[W];
      n_rem = q_bit ? trial[W-1:0] : {s_rem[W-2:0], s_in[W-1]};
   end

   // Iteration counter, partial remainder and shifting quotient
   always_ff @(posedge clk) begin
      if (!rst || abort) begin
         rem  <= '0;
         dvd  <= '0;
         cnt  <= '0;
         run  <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem <= n_rem;
            dvd <= {s_in[W-2:0], q_bit};
            cnt <= CW'(W - 1);
            run <= 1'b1;
         end else if (run) begin
            rem <= n_rem;
            dvd <= {s_in[W-2:0], q_bit};
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
               run  <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/calc_engine.sv
// Keypad calculator core: operand entry, operator
// latch, add/sub/mul in one cycle, sequential divide.
module calc_engine
   import calc_pkg::*;
#(
   parameter int W      = 11,
   parameter int DIGITS = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   input  logic [3:0]   key_code,
   output logic         busy,
   output logic [W-1:0] result,
   output logic         result_valid,
   output logic         err
);

   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] CMAX = CW'(DIGITS);
   localparam logic [W-1:0]  TEN  = W'(10);

   if (pow10(DIGITS) - 1 > (longint'(1) << (W - 1)) - 1) begin : g_bad_cfg
      $error("calc_engine: DIGITS too large for W");
   end

   calc_state_t  state;
   calc_op_t     op;
   logic [W-1:0] mag;
   logic         sgn;
   logic [CW-1:0] cnt;
   logic [W-1:0] op1;
   logic [W-1:0] op2;
   logic         q_neg;
   logic [W-1:0] q_raw;
   logic         fix_pend;

   logic           clr;
   logic           is_digit;
   logic           is_sign;
   logic           is_op;
   logic [3:0]     op_code;
   logic [W-1:0]   acc;
   logic [W-1:0]   entry;
   logic [W:0]     sum;
   logic [2*W-1:0] prod;
   logic [W-1:0]   ar_res;
   logic           ar_err;
   logic [W-1:0]   a_mag;
   logic [W-1:0]   b_mag;
   logic           div_start;
   logic [W-1:0]   quot;
   logic           div_done;

   // Key classification and arithmetic datapath
   always_comb begin
      clr      = key_valid && (key_code == KEY_CLEAR);
      is_digit = key_code < 4'd10;
      is_sign  = (key_code == KEY_PLUS) || (key_code == KEY_MINUS);
      is_op    = (key_code >= KEY_PLUS) && (key_code <= KEY_DIV);
      op_code  = key_code - KEY_PLUS;
      acc      = mag * TEN + {{(W-4){1'b0}}, key_code};
      entry    = sgn ? -mag : mag;
      if (op == OP_SUB) sum = {op1[W-1], op1} - {op2[W-1], op2};
      else              sum = {op1[W-1], op1} + {op2[W-1], op2};
      prod = {{W{op1[W-1]}}, op1} * {{W{op2[W-1]}}, op2};
      ar_res = '0;
      ar_err = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            ar_res = sum[W-1:0];
            ar_err = sum[W] ^ sum[W-1];
         end
         OP_MUL: begin
            ar_res = prod[W-1:0];
            ar_err = !((&prod[2*W-1:W-1]) || ~(|prod[2*W-1:W-1]));
         end
         default: ;
      endcase
      a_mag     = op1[W-1] ? -op1 : op1;
      b_mag     = op2[W-1] ? -op2 : op2;
      div_start = (state == S_EXEC) && (op == OP_DIV) && (op2 != '0);
   end

   calc_div_seq #(.W(W)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .abort    (clr),
      .dividend (a_mag),
      .divisor  (b_mag),
      .quotient (quot),
      .done     (div_done)
   );

   // Main FSM with registered outputs; CLEAR shares the reset path
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         state        <= S_OP1;
         op           <= OP_ADD;
         mag          <= '0;
         sgn          <= 1'b0;
         cnt          <= '0;
         op1          <= '0;
         op2          <= '0;
         q_neg        <= 1'b0;
         q_raw        <= '0;
         fix_pend     <= 1'b0;
         result       <= '0;
         err          <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (fix_pend) begin
            result       <= q_neg ? -q_raw : q_raw;
            err          <= !q_neg && q_raw[W-1];
            result_valid <= 1'b1;
            fix_pend     <= 1'b0;
         end
         case (state)
            S_OP1, S_OP2: begin
               if (key_valid) begin
                  if (is_sign) begin
                     if (cnt == '0) sgn <= (key_code == KEY_MINUS);
                  end else if (is_digit) begin
                     if (cnt < CMAX) begin
                        mag <= acc;
                        cnt <= cnt + 1'b1;
                     end
                  end else if (key_code == KEY_ENTER) begin
                     if (state == S_OP1) begin
                        op1   <= entry;
                        state <= S_OPR;
                     end else begin
                        op2   <= entry;
                        state <= S_EXEC;
                        busy  <= 1'b1;
                     end
                     mag <= '0;
                     sgn <= 1'b0;
                     cnt <= '0;
                  end
               end
            end
            S_OPR: begin
               if (key_valid && is_op) begin
                  op    <= calc_op_t'(op_code[1:0]);
                  state <= S_OP2;
               end
            end
            S_EXEC: begin
               if (op == OP_DIV && op2 != '0) begin
                  q_neg <= op1[W-1] ^ op2[W-1];
                  state <= S_DIV;
               end else begin
                  result       <= ar_res;
                  err          <= (op == OP_DIV) ? 1'b1 : ar_err;
                  result_valid <= 1'b1;
                  state        <= S_OP1;
                  busy         <= 1'b0;
               end
            end
            S_DIV: begin
               if (div_done) begin
                  q_raw    <= quot;
                  fix_pend <= 1'b1;
                  state    <= S_OP1;
                  busy     <= 1'b0;
               end
            end
            default: state <= S_OP1;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_engine.sv
// Directed-vector bench for calc_engine with
// hand-computed results per scenario.
module tb_calc_engine;
   import calc_pkg::*;

   localparam int W = 11;

   logic         clk;
   logic         rst;
   logic         key_valid;
   logic [3:0]   key_code;
   logic         busy;
   logic [W-1:0] result;
   logic         result_valid;
   logic         err;

   int passed;
   int total;

   logic [W-1:0] r;
   logic         e;
   int           lat;
   int           bc;

   calc_engine #(.W(W), .DIGITS(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic press(input logic [3:0] c);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'd0;
   endtask

   // Starts at the negedge right after the accepting edge (k=0)
   task automatic wait_result(output logic [W-1:0] rr, output logic ee,
                              output int ll, output int bb);
      rr = '0;
      ee = 1'b0;
      ll = -1;
      bb = 0;
      for (int k = 0; k < 30; k++) begin
         if (busy) bb++;
         if (result_valid) begin
            rr = result;
            ee = err;
            ll = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      key_valid = 1'b0;
      key_code = 4'd0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (result !== 11'd0) $display("FAIL reset_result got %h want 000", result);
      else passed++;
      total++;
      if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err);
      else passed++;
      total++;
      if (result_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", result_valid);
      else passed++;
      total++;
      if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
      else passed++;
   endtask

   task automatic test_add;
      press(KEY_MINUS); press(1); press(2); press(3); press(KEY_ENTER);
      press(KEY_PLUS); press(4); press(5); press(KEY_ENTER);
      wait_result(r, e, lat, bc);
      total++;
      if (lat !== 1) $display("FAIL add_latency got %0d want 1", lat);
      else passed++;
      total++;
      if (r !== 11'h7B2) $display("FAIL add_result got %h want 7b2", r);
      else passed++;
      total++;
      if (e !== 1'b0) $display("FAIL add_err got %b want 0", e);
      else passed++;
      @(negedge clk);
      total++;
      if (result_valid !== 1'b0) $display("FAIL add_pulse got %b want 0", result_valid);
      else passed++;
   endtask

   task automatic test_mul;
      press(9); press(9); press(9); press(KEY_ENTER);
      press(KEY_MUL); press(3); press(KEY_ENTER);
      wait_result(r, e, lat, bc);
      total++;
      if (r !== 11'd949) $display("FAIL mul_ovf_result got %0d want 949", r);
      else passed++;
      total++;
      if (e !== 1'b1) $display("FAIL mul_ovf_err got %b want 1", e);
      else passed++;
      press(KEY_MINUS); press(1); press(2); press(KEY_ENTER);
      press(KEY_MUL); press(5); press(KEY_ENTER);
      wait_result(r, e, lat, bc);
      total++;
      if (lat !== 1) $display("FAIL mul_neg_latency got %0d want 1", lat);
      else passed++;
      total++;
      if (r !== 11'h7C4) $display("FAIL mul_neg_result got %h want 7c4", r);
      else passed++;
      total++;
      if (e !== 1'b0) $display("FAIL mul_neg_err got %b want 0", e);
      else passed++;
   endtask

   task automatic test_div;
      press(KEY_MINUS); press(1); press(0); press(0); press(KEY_ENTER);
      press(KEY_DIV); press(7); press(KEY_ENTER);
      wait_result(r, e, lat, bc);
      total++;
      if (bc !== 12) $display("FAIL div_busy_cycles got %0d want 12", bc);
      else passed++;
      total++;
      if (lat !== 13) $display("FAIL div_latency got %0d want 13", lat);
      else passed++;
      total++;
      if (r !== 11'h7F2) $display("FAIL div_result got %h want 7f2", r);
      else passed++;
      total++;
      if (e !== 1'b0) $display("FAIL div_err got %b want 0", e);
      else passed++;
      @(negedge clk);
      total++;
      if (result_valid !== 1'b0) $display("FAIL div_pulse got %b want 0", result_valid);
      else passed++;
   endtask

   task automatic test_div_zero;
      press(5); press(KEY_ENTER); press(KEY_DIV); press(KEY_ENTER);
      wait_result(r, e, lat, bc);
      total++;
      if (lat !== 1) $display("FAIL dz_latency got %0d want 1", lat);
      else passed++;
      total++;
      if (r !== 11'd0) $display("FAIL dz_result got %h want 000", r);
      else passed++;
      total++;
      if (e !== 1'b1) $display("FAIL dz_err got %b want 1", e);
      else passed++;
      total++;
      if (bc !== 1) $display("FAIL dz_busy_cycles got %0d want 1", bc);
      else passed++;
   endtask

   task automatic test_digit_limit;
      press(1); press(2); press(3); press(4); press(KEY_ENTER);
      press(KEY_MINUS); press(2); press(3); press(KEY_ENTER);
      wait_result(r, e, lat, bc);
      total++;
      if (r !== 11'd100) $display("FAIL digit_limit_result got %0d want 100", r);
      else passed++;
      total++;
      if (e !== 1'b0) $display("FAIL digit_limit_err got %b want 0", e);
      else passed++;
   endtask

   task automatic test_clear_reset;
      int rvs;
      rvs = 0;
      press(KEY_MINUS); press(1); press(0); press(0); press(KEY_ENTER);
      press(KEY_DIV); press(7); press(KEY_ENTER);
      repeat (4) @(negedge clk);
      total++;
      if (busy !== 1'b1) $display("FAIL clr_pre_busy got %b want 1", busy);
      else passed++;
      press(KEY_CLEAR);
      for (int k = 0; k < 20; k++) begin
         if (result_valid) rvs++;
         @(negedge clk);
      end
      total++;
      if (busy !== 1'b0) $display("FAIL clr_busy got %b want 0", busy);
      else passed++;
      total++;
      if (result !== 11'd0) $display("FAIL clr_result got %h want 000", result);
      else passed++;
      total++;
      if (err !== 1'b0) $display("FAIL clr_err got %b want 0", err);
      else passed++;
      press(3); press(KEY_ENTER); press(KEY_PLUS); press(4);
      @(negedge clk);
      rst = 1'b0;
      if (result_valid) rvs++;
      @(negedge clk);
      rst = 1'b1;
      if (result_valid) rvs++;
      total++;
      if (rvs !== 0) $display("FAIL clr_no_valid got %0d pulses want 0", rvs);
      else passed++;
      total++;
      if ({busy, err, result} !== 13'd0) $display("FAIL rst_outputs got %h want 0000", {busy, err, result});
      else passed++;
      press(7); press(KEY_ENTER); press(KEY_PLUS); press(8); press(KEY_ENTER);
      wait_result(r, e, lat, bc);
      total++;
      if (lat !== 1) $display("FAIL post_rst_latency got %0d want 1", lat);
      else passed++;
      total++;
      if (r !== 11'd15) $display("FAIL post_rst_result got %0d want 15", r);
      else passed++;
      total++;
      if (e !== 1'b0) $display("FAIL post_rst_err got %b want 0", e);
      else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst = 1'b0;
      key_valid = 1'b0;
      key_code = 4'd0;
      test_reset;
      test_add;
      test_mul;
      test_div;
      test_div_zero;
      test_digit_limit;
      test_clear_reset;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/calc_engine.md
# calc_engine

Sequential keypad calculator core: accepts decoded key codes one per strobe, builds two signed decimal operands of up to DIGITS digits plus an operator, then computes add, subtract, multiply or divide and presents a registered signed result with a valid pulse and an error flag. Sits between the keyboard scan-code decoder (which supplies 4-bit key codes) and the display driver. It generalises the earlier add/sub-only entry block:

- all logic runs in the `clk` domain; there is no strobe-edge clocking;
- result width and digit count are set by parameters;
- multiply, divide, overflow and divide-by-zero detection, and a clear key are new.

## Interface
- `W`, 11: result and operand width in bits, signed two's complement.
- `DIGITS`, 3: maximum decimal digits per operand. Constraint: 10^DIGITS − 1 ≤ 2^(W−1) − 1. An elaboration-time check fails the build if this is violated.
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `key_valid`  in  1  one-cycle strobe; `key_code` is sampled when this is high.
- `key_code`  in  4  0–9 digit, 10 `+`, 11 `-`, 12 `*`, 13 `/`, 14 ENTER, 15 CLEAR.
- `busy`  out  1  high in EXEC and DIV. Keys other than CLEAR are ignored while high.
- `result`  out  W  signed result, held until the next computation or CLEAR.
- `result_valid`  out  1  one-cycle pulse when `result`/`err` update from a computation.
- `err`  out  1  overflow or divide-by-zero on the last computation; sticky until next result or CLEAR.

## Operation
- States: OP1, OPR, OP2, EXEC, DIV. Reset state is OP1.
- Reset (`rst`=0 at an edge): `result`=0, `err`=0, `result_valid`=0, `busy`=0. Both operands, sign flags, digit counters and the operator register are cleared. The operator resets to add.
- OP1/OP2 (operand entry):
  - `+` or `-` with digit count 0 sets the sign flag (last one wins). Once a digit has been entered, these keys are ignored.
  - A digit with count < DIGITS: magnitude ← magnitude×10 + d, count increments. Further digits are ignored.
  - `*` and `/` are ignored.
  - ENTER negates the magnitude if the sign flag is set and stores the operand. ENTER with zero digits stores 0.
  - ENTER in OP1 → OPR. ENTER in OP2 → EXEC.
- OPR: keys 10–13 latch the operator (add/sub/mul/div) and go to OP2. Digits and ENTER are ignored.
- EXEC (one cycle):
  - add/sub/mul: compute at full width, W+1 bits for add/sub and 2W bits for mul. `result` ← low W bits. `err` ← 1 if the true value lies outside [−2^(W−1), 2^(W−1)−1]. Then `result_valid` pulses and the state goes to OP1.
  - div: if the divisor is 0, `result` ← 0, `err` ← 1, pulse, → OP1. Otherwise start the divider on the magnitudes and go to DIV.
- DIV: waits for the divider's done signal, then:
  - quotient sign = sign1 XOR sign2, truncating toward zero; the remainder is discarded;
  - `err` ← 1 only for −2^(W−1) / −1;
  - pulse `result_valid`, → OP1.
- CLEAR from any state (including DIV) returns to OP1 and does everything reset does except the reset itself. The divider is aborted and `result_valid` is not pulsed.
- `key_valid` together with an ignored code has no effect.

## Timing
- A key is accepted at the edge where `key_valid`=1. The state update is visible in the next cycle.
- add/sub/mul: second ENTER accepted at edge t. EXEC runs during cycle t→t+1. `result`, `err` and `result_valid`=1 become visible after edge t+1, i.e. one cycle of latency after acceptance.
- div: `busy` is high from edge t for W+1 cycles. The result is visible after edge t+W+2: one EXEC cycle, W divider iterations, and one cycle for the sign fix.
- `result_valid` is high for exactly one cycle per computation and is never asserted in the same cycle as reset or CLEAR.
- There is no back-pressure. Keys arriving while `busy`=1 are dropped, except CLEAR.

## Structure
- Package `calc_pkg` holds:
  - key code constants `KEY_PLUS`, `KEY_MINUS`, `KEY_MUL`, `KEY_DIV`, `KEY_ENTER`, `KEY_CLEAR`;
  - the state enum `calc_state_t`;
  - the operator enum `calc_op_t`.
- Sub-module `calc_div_seq`, a parametrised W-bit unsigned restoring divider:
  - ports `clk`, `rst`, `start`, `abort`, `dividend`, `divisor`, `quotient`, `done`;
  - one quotient bit per cycle; `done` is a one-cycle pulse.

## Test plan
- Keys `-`,1,2,3,ENTER,`+`,4,5,ENTER → `result`=11'h7B2 (−78), `err`=0, `result_valid` one cycle, one cycle after the final ENTER.
- 9,9,9,ENTER,`*`,3,ENTER → `result`=949 (2997 mod 2048), `err`=1.
- `-`,1,0,0,ENTER,`/`,7,ENTER → `busy` high for 12 cycles, `result`=−14 (11'h7F2), `err`=0, valid 13 cycles after ENTER.
- 5,ENTER,`/`,ENTER → `result`=0, `err`=1, no DIV state entered.
- 1,2,3,4,ENTER,`-`,2,3,ENTER → fourth digit ignored, `result`=100.
- Mid-division CLEAR, then `rst` low mid-entry → no `result_valid`, all outputs 0, next full sequence 7,ENTER,`+`,8,ENTER gives 15.
